// File: rtl/apb4_mem_pkg.sv
// Shared types and limits for the APB4 memory slave: FSM state and wait-count bounds.
// No logic, so no latency or backpressure.
package apb4_mem_pkg;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Word-address width for the storage array, never narrower than one bit.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb4_mem_array.sv
// Word storage with per-word valid bits: byte-strobed synchronous write, asynchronous read.
// Write lands on the next PCLK edge; read is combinational; always accepts, no backpressure.
module apb4_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    // Data contents deliberately have no reset; only the valid bits are cleared.
    always_ff @(posedge PCLK) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            vld_q <= '0;
        end else if (we && (|wstrb)) begin
            vld_q[waddr] <= 1'b1;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = vld_q[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 slave backed by a DEPTH-word memory, with WAIT_CYC wait states per transfer.
// Latency: PREADY after WAIT_CYC ACCESS cycles; backpressure is PREADY low while waiting.
module apb4_mem_slave
    import apb4_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam int AW    = addr_bits(DEPTH);

    localparam logic [CNT_W-1:0]  WAIT_LD   = (WAIT_CYC > WAIT_MAX) ? CNT_W'(WAIT_MAX)
                                                                    : CNT_W'(WAIT_CYC);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'(BYTES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] index;
    logic              out_of_range;
    logic              misalign;
    logic              err;
    logic              pready;
    logic              we;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    // Range check runs on the full-width index so high addresses cannot alias low words.
    assign index        = PADDR >> OFS_W;
    assign out_of_range = ({1'b0, index} >= DEPTH_EXT);
    assign misalign     = ((PADDR & OFS_MASK) != '0);
    assign err          = out_of_range | misalign | (!PWRITE && !rd_valid);

    assign pready = (state_q == ACCESS) && (cnt_q == '0) && PSEL && PENABLE;
    assign we     = pready && PWRITE && !err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                end
            end
            ACCESS: begin
                // Dropping PSEL abandons the transfer; nothing is committed.
                if (!PSEL || pready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    apb4_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (we),
        .waddr   (index[AW-1:0]),
        .wstrb   (PSTRB),
        .wdata   (PWDATA),
        .raddr   (index[AW-1:0]),
        .rdata   (rd_data),
        .rvalid  (rd_valid)
    );

    assign PREADY  = pready;
    assign PRDATA  = (pready && !PWRITE && !err) ? rd_data : '0;
    assign PSLVERR = pready && err;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three instances (WAIT_CYC 0, 3, 2) on a shared APB bus with per-instance PSEL.
// Table of transfers plus hand-written abort and reset sequences, scoreboarded on PREADY.
module tb_apb4_mem_slave;

    logic        PCLK;
    logic        PRESETn;
    logic [2:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  pready;
    logic [31:0] prdata [3];
    logic [2:0]  pslverr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          inst;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb4_mem_slave #(
            .DATA_W   (32),
            .ADDR_W   (32),
            .DEPTH    (32),
            .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .PCLK    (PCLK),
            .PRESETn (PRESETn),
            .PSEL    (psel[g]),
            .PENABLE (PENABLE),
            .PWRITE  (PWRITE),
            .PADDR   (PADDR),
            .PWDATA  (PWDATA),
            .PSTRB   (PSTRB),
            .PREADY  (pready[g]),
            .PRDATA  (prdata[g]),
            .PSLVERR (pslverr[g])
        );
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input int exp_waits);
        vec_t v;
        v.inst = inst; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_waits = exp_waits;
        return v;
    endfunction

    task automatic drive_setup(input vec_t v);
        psel          = '0;
        psel[v.inst]  = 1'b1;
        PENABLE       = 1'b0;
        PWRITE        = v.wr;
        PADDR         = v.addr;
        PWDATA        = v.wdata;
        PSTRB         = v.strb;
    endtask

    // Called just after a rising edge; returns just after the completion edge, bus idle.
    task automatic xfer(input vec_t v, input string name);
        vec_t e;
        int   waits;
        bit   done;
        drive_setup(v);
        sb.push_back(v);
        @(posedge PCLK); #1 PENABLE = 1'b1;
        waits = 0;
        done  = 0;
        while (!done && waits < 40) begin
            @(negedge PCLK);
            if (pready[v.inst]) begin
                done = 1;
            end else begin
                chk({name, " wait-out"}, prdata[v.inst] | {31'b0, pslverr[v.inst]}, 32'h0);
                waits++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: PREADY low for %0d cycles, required after %0d", name, waits, e.exp_waits);
        end else begin
            chk({name, " waits"}, 32'(waits), 32'(e.exp_waits));
            chk({name, " pslverr"}, {31'b0, pslverr[e.inst]}, {31'b0, e.exp_err});
            chk({name, " prdata"}, prdata[e.inst], e.exp_rdata);
        end
        @(posedge PCLK); #1;
        psel    = '0;
        PENABLE = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        psel    = '0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;

        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset pready[%0d]", i), {31'b0, pready[i]}, 32'h0);
            chk($sformatf("reset pslverr[%0d]", i), {31'b0, pslverr[i]}, 32'h0);
            chk($sformatf("reset prdata[%0d]", i), prdata[i], 32'h0);
        end
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // ACCESS without SETUP on the zero-wait instance must be ignored.
        psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("no-setup pready", {31'b0, pready[0]}, 32'h0);
        end
        @(posedge PCLK); #1 psel = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1;

        vecs.push_back(mk(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h04, 32'h0,        4'hF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 32'h08, 32'h11223344, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h08, 32'hAABBCCDD, 4'h5, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h08, 32'h0,        4'h0, 0, 32'h11BB33DD, 0));
        vecs.push_back(mk(0, 1, 32'h00, 32'hCAFE0001, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0C, 32'h0,        4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h80, 32'h0,        4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h02, 32'h12345678, 4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0,        4'hF, 0, 32'hCAFE0001, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFF80, 32'h55555555, 4'hF, 1, 32'h0,  0));
        vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'h0,  4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0,        4'hF, 0, 32'hCAFE0001, 0));
        vecs.push_back(mk(0, 1, 32'h7C, 32'hA5A5A5A5, 4'h0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h7C, 32'h0,        4'hF, 1, 32'h0,        0));
        vecs.push_back(mk(0, 1, 32'h7C, 32'h01020304, 4'hF, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h7C, 32'h0,        4'h0, 0, 32'h01020304, 0));
        vecs.push_back(mk(0, 0, 32'h04, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 1, 32'h04, 32'h0BADF00D, 4'hF, 0, 32'h0,        3));
        vecs.push_back(mk(1, 0, 32'h04, 32'h0,        4'hF, 0, 32'h0BADF00D, 3));
        vecs.push_back(mk(2, 1, 32'h14, 32'h13579BDF, 4'hF, 0, 32'h0,        2));
        vecs.push_back(mk(2, 0, 32'h14, 32'h0,        4'hF, 0, 32'h13579BDF, 2));

        // Each transfer's SETUP follows the previous completion edge directly.
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: PSEL drops during the wait phase of a write; the word must stay unwritten.
        drive_setup(mk(1, 1, 32'h10, 32'h77777777, 4'hF, 0, 32'h0, 0));
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        chk("abort pready", {31'b0, pready[1]}, 32'h0);
        @(posedge PCLK); #1 psel = '0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        xfer(mk(1, 0, 32'h10, 32'h0, 4'hF, 1, 32'h0, 3), "abort readback");

        // Reset during the wait phase of a write to 0x10.
        drive_setup(mk(2, 1, 32'h10, 32'h99999999, 4'hF, 0, 32'h0, 0));
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rst-wait pready before", {31'b0, pready[2]}, 32'h0);
        PRESETn = 1'b0;
        #1;
        chk("rst-wait pready", {31'b0, pready[2]}, 32'h0);
        chk("rst-wait pslverr", {31'b0, pslverr[2]}, 32'h0);
        chk("rst-wait prdata", prdata[2], 32'h0);
        repeat (3) @(posedge PCLK);
        #1 psel = '0; PENABLE = 1'b0; PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(mk(2, 0, 32'h10, 32'h0, 4'hF, 1, 32'h0, 2), "rst-wait readback");
        xfer(mk(0, 0, 32'h04, 32'h0, 4'hF, 1, 32'h0, 0), "post-reset read 0x04");

        // Reset while a read is being acknowledged: outputs must drop immediately.
        xfer(mk(0, 1, 32'h20, 32'h2468ACE0, 4'hF, 0, 32'h0, 0), "pre-rst write 0x20");
        drive_setup(mk(0, 0, 32'h20, 32'h0, 4'hF, 0, 32'h0, 0));
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rst-ack pready before", {31'b0, pready[0]}, 32'h1);
        chk("rst-ack prdata before", prdata[0], 32'h2468ACE0);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst-ack pready", {31'b0, pready[0]}, 32'h0);
        chk("rst-ack prdata", prdata[0], 32'h0);
        chk("rst-ack pslverr", {31'b0, pslverr[0]}, 32'h0);
        @(posedge PCLK); #1 psel = '0; PENABLE = 1'b0; PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(mk(0, 0, 32'h20, 32'h0, 4'hF, 1, 32'h0, 0), "rst-ack readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
